pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/redirect sequencer for the 5-stage MIPS32 pipeline (PC, IF, ID, EX, MEM, WB).
//  Merges the ID load-use stall request, the EX multi-cycle (MUL/DIV) stall request and the
//  ID branch decision into one per-stage stall vector, PC redirect and IF/ID flush.
//  Holds a small FSM and down-counter that keep the front end frozen for the full EX latency,
//  and a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  CNT_W        5   width of exCycles_i and of the internal EX wait counter
//  STALL_CNT_W  16  width of the saturating stall-cycle counter stallCount_o
// PORTS
//  clk            in   1            system clock; all state updates on posedge
//  rst            in   1            reset, synchronous, active-high
//  stallReqID_i   in   1            ID load-use hazard; level, held by ID while the hazard exists
//  stallReqEX_i   in   1            EX starting a multi-cycle op; sampled in RUN only
//  exCycles_i     in   CNT_W        total EX cycles of that op (valid with stallReqEX_i)
//  branchEnable_i in   1            ID resolved a taken branch/jump this cycle
//  branchAddr_i   in   32           branch target (valid with branchEnable_i)
//  stall_o        out  6            [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
//  newPCValid_o   out  1            PC loads newPC_o this cycle
//  newPC_o        out  32           redirect target
//  flush_o        out  1            squash the IF/ID register this cycle
//  busy_o         out  1            1 while FSM is in EXWAIT
//  stallCount_o   out  STALL_CNT_W  cycles with stall_o != 0 since reset, saturating
// BEHAVIOUR
//  - rst=1 at posedge: state<=RUN, cnt<=0, stallCount_o<=0. While rst=1 all outputs are
//    driven 0 combinationally; rst mid-EXWAIT aborts the wait with no residual stall.
//  - FSM states: RUN, EXWAIT. cnt is CNT_W bits, unsigned.
//  - RUN, stallReqEX_i=1 and exCycles_i>=2: stall_o=6'b001111 this cycle; cnt<=exCycles_i-1;
//    next state EXWAIT. Total front-end stall = exCycles_i cycles, including the request cycle.
//  - RUN, stallReqEX_i=1 and exCycles_i<=1: no EX stall, treated as single-cycle op.
//  - RUN, stallReqID_i=1 and no EX stall this cycle: stall_o=6'b000111 (PC, IF, ID held,
//    bubble into EX); combinational, same cycle, no state change.
//  - EX stall has priority over ID stall; both together -> 6'b001111.
//  - EXWAIT: stall_o=6'b001111 every cycle; cnt<=cnt-1; when cnt==1 this is the last stall
//    cycle and next state is RUN. stallReqEX_i and stallReqID_i are ignored in EXWAIT.
//    The EX stall covers any ID hazard; ID re-asserts its request after return to RUN if still valid.
//  - MEM and WB are never stalled (stall_o[5:4]=0 always).
//  - Redirect: newPCValid_o = branchEnable_i & (stall_o==0); newPC_o = branchAddr_i when valid,
//    else 0. A branch seen while stalled is not buffered: ID holds it and re-presents it in the
//    first unstalled cycle.
//  - stallCount_o increments by 1 at each posedge with stall_o!=0 and rst=0. It holds at
//    all-ones (saturates) and never wraps.
//  - busy_o = (state==EXWAIT).
// CONFIGURATION
//  CTRL_DELAY_SLOT_EN defined: MIPS branch delay slot is honoured. flush_o is tied 0 and the
//    instruction in IF completes normally.
//  CTRL_DELAY_SLOT_EN undefined: flush_o = newPCValid_o (same cycle), squashing the
//    wrong-path instruction in IF/ID.
// TESTING
//  1. rst=1 for 2 cycles with stallReqEX_i=1 -> all outputs 0. After release: state RUN,
//     stallCount_o=0.
//  2. RUN, stallReqEX_i=1, exCycles_i=4 -> stall_o=6'b001111 for exactly 4 cycles, busy_o=1
//     for cycles 2-4, then stall_o=0; stallCount_o=4.
//  3. stallReqID_i=1 for 3 cycles -> stall_o=6'b000111 for 3 cycles. stallReqEX_i with
//     exCycles_i=1 -> no stall.
//  4. branchEnable_i=1, branchAddr_i=32'h0000_0040, no stall -> newPCValid_o=1, newPC_o=0x40.
//     flush_o=1 when macro undefined, 0 when defined. Repeat with stallReqID_i=1 -> newPCValid_o=0.
//  5. exCycles_i=8; assert rst in the 3rd stall cycle -> next cycle stall_o=0, busy_o=0,
//     stallCount_o=0.
//  6. Preload stallCount_o to all-ones (force or STALL_CNT_W=2 build) plus more stalls ->
//     stallCount_o holds at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall / redirect sequencer for the 5-stage MIPS32 pipeline.
// It merges the ID load-use stall, the EX multi-cycle stall and the ID branch decision
// into one per-stage stall vector, a PC redirect and an IF/ID flush.
// A two-state FSM (RUN / EXWAIT) with a down-counter holds the front end frozen for
// the full latency of a multi-cycle EX operation. A saturating counter records stalled
// cycles for performance debug.
//
// Build option: define CTRL_DELAY_SLOT_EN to honour the MIPS branch delay slot
// (flush_o tied low). When it is undefined, flush_o follows newPCValid_o and squashes
// the wrong-path instruction sitting in IF/ID.
//
// While rst is high, every output is forced to zero combinationally. A reset taken in
// the middle of an EX wait therefore releases the pipeline in the same cycle.

module pipeline_ctrl #(
  parameter int CNT_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallReqID_i,
  input  logic                   stallReqEX_i,
  input  logic [CNT_W-1:0]       exCycles_i,
  input  logic                   branchEnable_i,
  input  logic [31:0]            branchAddr_i,
  output logic [5:0]             stall_o,
  output logic                   newPCValid_o,
  output logic [31:0]            newPC_o,
  output logic                   flush_o,
  output logic                   busy_o,
  output logic [STALL_CNT_W-1:0] stallCount_o
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_EXWAIT = 1'b1
  } state_t;

  // Stall patterns: the EX pattern also freezes EX; the ID pattern inserts a bubble into EX.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_TWO   = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [STALL_CNT_W-1:0] SCNT_ZERO = {STALL_CNT_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] SCNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                     ex_start_s;
  logic [5:0]               stall_s;
  logic                     redirect_s;

  // A multi-cycle EX request is acted on only in RUN, and only when it needs more than one cycle.
  always_comb begin
    ex_start_s = 1'b0;
    if ((state_q == ST_RUN) && stallReqEX_i && (exCycles_i >= CNT_TWO)) begin
      ex_start_s = 1'b1;
    end else begin
      ex_start_s = 1'b0;
    end
  end

  // Stall vector: reset wins, then EXWAIT, then a new EX request, then the ID hazard.
  always_comb begin
    stall_s = STALL_NONE;
    if (rst) begin
      stall_s = STALL_NONE;
    end else if (state_q == ST_EXWAIT) begin
      stall_s = STALL_EX;
    end else if (ex_start_s) begin
      stall_s = STALL_EX;
    end else if (stallReqID_i) begin
      stall_s = STALL_ID;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  // Redirect only in a fully unstalled cycle; ID re-presents a branch that arrived while stalled.
  always_comb begin
    redirect_s = 1'b0;
    if (!rst && branchEnable_i && (stall_s == STALL_NONE)) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
  end

  // FSM next state and EX wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_start_s) begin
          // The request cycle itself is one of the exCycles_i stall cycles.
          state_d = ST_EXWAIT;
          cnt_d   = exCycles_i - CNT_ONE;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q;
        end
      end
      ST_EXWAIT: begin
        if (cnt_q <= CNT_ONE) begin
          // Last stall cycle; a zero count cannot normally occur, so it is also treated as done.
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_EXWAIT;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_s != STALL_NONE) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + SCNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, EX wait counter and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= CNT_ZERO;
      stall_cnt_q <= SCNT_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive; everything reads zero while reset is asserted.
  always_comb begin
    stall_o      = stall_s;
    newPCValid_o = redirect_s;
    newPC_o      = 32'h0000_0000;
    busy_o       = 1'b0;
    stallCount_o = SCNT_ZERO;
    if (redirect_s) begin
      newPC_o = branchAddr_i;
    end else begin
      newPC_o = 32'h0000_0000;
    end
    if (rst) begin
      busy_o       = 1'b0;
      stallCount_o = SCNT_ZERO;
    end else begin
      busy_o       = (state_q == ST_EXWAIT);
      stallCount_o = stall_cnt_q;
    end
  end

`ifdef CTRL_DELAY_SLOT_EN
  // Delay slot honoured: the instruction in IF always completes.
  always_comb begin
    flush_o = 1'b0;
  end
`else
  // No delay slot: squash the wrong-path instruction in the redirect cycle.
  always_comb begin
    flush_o = redirect_s;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: table of single-cycle vectors in RUN plus
// hand-written sequences for reset, EX wait, reset abort and counter saturation.
`timescale 1ns/1ps

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallReqID_i;
  logic        stallReqEX_i;
  logic [4:0]  exCycles_i;
  logic        branchEnable_i;
  logic [31:0] branchAddr_i;

  logic [5:0]  stall_o,      s_stall_o;
  logic        newPCValid_o, s_newPCValid_o;
  logic [31:0] newPC_o,      s_newPC_o;
  logic        flush_o,      s_flush_o;
  logic        busy_o,       s_busy_o;
  logic [15:0] stallCount_o;
  logic [1:0]  s_stallCount_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;   // model of the 16-bit stall counter
  int exp_sat = 0;   // model of the 2-bit saturating counter

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(5), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .stallReqID_i(stallReqID_i), .stallReqEX_i(stallReqEX_i), .exCycles_i(exCycles_i),
    .branchEnable_i(branchEnable_i), .branchAddr_i(branchAddr_i),
    .stall_o(stall_o), .newPCValid_o(newPCValid_o), .newPC_o(newPC_o),
    .flush_o(flush_o), .busy_o(busy_o), .stallCount_o(stallCount_o)
  );

  pipeline_ctrl #(.CNT_W(5), .STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .stallReqID_i(stallReqID_i), .stallReqEX_i(stallReqEX_i), .exCycles_i(exCycles_i),
    .branchEnable_i(branchEnable_i), .branchAddr_i(branchAddr_i),
    .stall_o(s_stall_o), .newPCValid_o(s_newPCValid_o), .newPC_o(s_newPC_o),
    .flush_o(s_flush_o), .busy_o(s_busy_o), .stallCount_o(s_stallCount_o)
  );

  typedef struct {
    logic        id;
    logic        ex;
    logic [4:0]  cyc;
    logic        br;
    logic [31:0] addr;
    logic [5:0]  e_stall;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs shortly after the rising edge.
  task automatic drive(input logic r, input logic id, input logic ex, input logic [4:0] cyc,
                       input logic br, input logic [31:0] addr);
    @(posedge clk);
    #1;
    rst            = r;
    stallReqID_i   = id;
    stallReqEX_i   = ex;
    exCycles_i     = cyc;
    branchEnable_i = br;
    branchAddr_i   = addr;
  endtask

  // Check outputs mid-cycle, then advance the counter models for this cycle.
  task automatic check_out(input string name, input logic [5:0] e_stall, input logic e_valid,
                           input logic [31:0] e_pc, input logic e_busy);
    logic e_flush;
`ifdef CTRL_DELAY_SLOT_EN
    e_flush = 1'b0;
`else
    e_flush = e_valid;
`endif
    #4;
    chk({name, ".stall"}, {26'd0, stall_o}, {26'd0, e_stall});
    chk({name, ".valid"}, {31'd0, newPCValid_o}, {31'd0, e_valid});
    chk({name, ".pc"}, newPC_o, e_pc);
    chk({name, ".flush"}, {31'd0, flush_o}, {31'd0, e_flush});
    chk({name, ".busy"}, {31'd0, busy_o}, {31'd0, e_busy});
    chk({name, ".count"}, {16'd0, stallCount_o}, exp_cnt);
    chk({name, ".satcount"}, {30'd0, s_stallCount_o}, exp_sat);
    if (e_stall != 6'd0) begin
      exp_cnt++;
      if (exp_sat < 3) exp_sat++;
    end
  endtask

  initial begin
    rst = 1'b1; stallReqID_i = 1'b0; stallReqEX_i = 1'b1; exCycles_i = 5'd4;
    branchEnable_i = 1'b1; branchAddr_i = 32'h0000_0080;

    //              id    ex    cyc   br    addr            stall      valid pc
    vecs[0]  = '{1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 6'b000000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 6'b000111, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 6'b000111, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 6'b000111, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd1, 1'b0, 32'h0000_0000, 6'b000000, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 6'b000000, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 5'd1, 1'b0, 32'h0000_0000, 6'b000111, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0040, 6'b000000, 1'b1, 32'h0000_0040};
    vecs[8]  = '{1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0040, 6'b000111, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd1, 1'b1, 32'hDEAD_BEE0, 6'b000000, 1'b1, 32'hDEAD_BEE0};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_1234, 6'b000000, 1'b0, 32'h0};

    // Reset held two cycles with EX request and branch present: all outputs zero.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 32'h0000_0080);
      check_out("reset", 6'b000000, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("post_reset", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Single-cycle behaviour in RUN.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].id, vecs[i].ex, vecs[i].cyc, vecs[i].br, vecs[i].addr);
      check_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_valid, vecs[i].e_pc, 1'b0);
    end

    // EX wait of 4 cycles; requests and branch during EXWAIT are ignored.
    drive(1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0);
    check_out("ex4_c1", 6'b001111, 1'b0, 32'h0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 32'h0000_0100);
      check_out($sformatf("ex4_c%0d", i), 6'b001111, 1'b0, 32'h0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0100);
    check_out("ex4_done", 6'b000000, 1'b1, 32'h0000_0100, 1'b0);

    // EX and ID together: EX pattern wins; wait 2 cycles.
    drive(1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 32'h0);
    check_out("exid_c1", 6'b001111, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("exid_c2", 6'b001111, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("exid_idagain", 6'b000111, 1'b0, 32'h0, 1'b0);

    // exCycles 8, reset asserted in the 3rd stall cycle aborts the wait.
    drive(1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h0);
    check_out("abort_c1", 6'b001111, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("abort_c2", 6'b001111, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    exp_cnt = 0;
    exp_sat = 0;
    check_out("abort_rst", 6'b000000, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("abort_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Saturation: 5 ID stall cycles; the 2-bit counter holds at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
      check_out($sformatf("sat%0d", i), 6'b000111, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_out("sat_end", 6'b000000, 1'b0, 32'h0, 1'b0);
    chk("sat_allones", {30'd0, s_stallCount_o}, 32'd3);
    chk("count_five", {16'd0, stallCount_o}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
